btb_tagged: RTL and testbench

- Parametrised, tagged, direct-mapped branch target buffer for the fetch stage.
- Each entry holds a 2-bit saturating direction counter, so the block predicts both target and taken/not-taken.
- Fetch presents the current PC on the lookup port; the prediction is registered and appears one cycle later.
- Execute writes resolved branches through the update port; decode/commit can flush the whole table.

---
 rtl/btb_tagged_if.sv | 36 +++
 rtl/btb_tagged.sv | 153 +++++++++++++++
 tb/tb_btb_tagged.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/btb_tagged_if.sv
// ============================================================================
// Module      : btb_tagged_if
// Description : Lookup / prediction / update / flush bundle for btb_tagged.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface btb_tagged_if;
  logic        lookup_valid;
  logic [31:0] lookup_pc;
  logic        pred_valid;
  logic        pred_hit;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [31:0] upd_target;
  logic        upd_taken;
  logic        flush;

  // Fetch/execute side
  modport master (
    output lookup_valid, lookup_pc,
    output upd_valid, upd_pc, upd_target, upd_taken, flush,
    input  pred_valid, pred_hit, pred_taken, pred_target
  );

  // Branch target buffer side
  modport slave (
    input  lookup_valid, lookup_pc,
    input  upd_valid, upd_pc, upd_target, upd_taken, flush,
    output pred_valid, pred_hit, pred_taken, pred_target
  );
endinterface

`default_nettype wire

// File: rtl/btb_tagged.sv
// ============================================================================
// Module      : btb_tagged
// Description : Tagged direct-mapped BTB with 2-bit direction counters and a
//               one-cycle registered prediction. Optional BTB_PERF_EN adds
//               lookup/hit performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module btb_tagged #(
  parameter int ENTRIES  = 16,
  parameter int TAG_BITS = 8
) (
  input  logic               clk,
  input  logic               rst,
  btb_tagged_if.slave        bus
`ifdef BTB_PERF_EN
  ,
  output logic [31:0]        perf_lookups,
  output logic [31:0]        perf_hits
`endif
);

  localparam int IDX = $clog2(ENTRIES);
  // PC bits that participate in index or tag; the rest are don't-care
  localparam logic [31:0] PC_USED_MASK =
    32'((((64'd1 << (IDX + TAG_BITS)) - 64'd1) << 2));

  // --------------------------------------------------------------------------
  // Table storage
  // --------------------------------------------------------------------------
  logic [ENTRIES-1:0]  valid_q;
  logic [TAG_BITS-1:0] tag_q    [ENTRIES];
  logic [31:0]         target_q [ENTRIES];
  logic [1:0]          ctr_q    [ENTRIES];

  // --------------------------------------------------------------------------
  // Lookup side (reads current contents, so same-cycle writes are not seen)
  // --------------------------------------------------------------------------
  logic [IDX-1:0]      lk_idx;
  logic [TAG_BITS-1:0] lk_tag;
  logic                lk_hit;
  logic                lk_taken;

  assign lk_idx   = bus.lookup_pc[IDX+1:2];
  assign lk_tag   = bus.lookup_pc[IDX+TAG_BITS+1:IDX+2];
  assign lk_hit   = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign lk_taken = lk_hit && ctr_q[lk_idx][1];

  // --------------------------------------------------------------------------
  // Update side
  // --------------------------------------------------------------------------
  logic [IDX-1:0]      upd_idx;
  logic [TAG_BITS-1:0] upd_tag;
  logic                upd_hit;
  logic [1:0]          ctr_d;

  assign upd_idx = bus.upd_pc[IDX+1:2];
  assign upd_tag = bus.upd_pc[IDX+TAG_BITS+1:IDX+2];
  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  always_comb begin
    ctr_d = ctr_q[upd_idx];
    if (bus.upd_taken) begin
      if (ctr_q[upd_idx] != 2'd3) ctr_d = ctr_q[upd_idx] + 2'd1;
    end else begin
      if (ctr_q[upd_idx] != 2'd0) ctr_d = ctr_q[upd_idx] - 2'd1;
    end
  end

  // Flush clears only valid bits and takes priority over a same-cycle update
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= '0;
      end
    end else if (bus.flush) begin
      valid_q <= '0;
    end else if (bus.upd_valid) begin
      if (upd_hit) begin
        target_q[upd_idx] <= bus.upd_target;
        ctr_q[upd_idx]    <= ctr_d;
      end else if (bus.upd_taken) begin
        valid_q[upd_idx]  <= 1'b1;
        tag_q[upd_idx]    <= upd_tag;
        target_q[upd_idx] <= bus.upd_target;
        ctr_q[upd_idx]    <= 2'd2;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Registered prediction
  // --------------------------------------------------------------------------
  logic        pred_valid_q;
  logic        pred_hit_q;
  logic        pred_taken_q;
  logic [31:0] pred_target_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pred_valid_q  <= 1'b0;
      pred_hit_q    <= 1'b0;
      pred_taken_q  <= 1'b0;
      pred_target_q <= '0;
    end else if (bus.lookup_valid) begin
      pred_valid_q  <= 1'b1;
      pred_hit_q    <= lk_hit;
      pred_taken_q  <= lk_taken;
      pred_target_q <= lk_hit ? target_q[lk_idx] : 32'd0;
    end else begin
      pred_valid_q  <= 1'b0;
      pred_hit_q    <= 1'b0;
      pred_taken_q  <= 1'b0;
    end
  end

  assign bus.pred_valid  = pred_valid_q;
  assign bus.pred_hit    = pred_hit_q;
  assign bus.pred_taken  = pred_taken_q;
  assign bus.pred_target = pred_target_q;

  // --------------------------------------------------------------------------
  // Performance counters
  // --------------------------------------------------------------------------
`ifdef BTB_PERF_EN
  logic [31:0] perf_lookups_q;
  logic [31:0] perf_hits_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_lookups_q <= '0;
      perf_hits_q    <= '0;
    end else if (bus.lookup_valid) begin
      perf_lookups_q <= perf_lookups_q + 32'd1;
      if (lk_hit) perf_hits_q <= perf_hits_q + 32'd1;
    end
  end

  assign perf_lookups = perf_lookups_q;
  assign perf_hits    = perf_hits_q;
`endif

  logic unused_pc_bits;
  assign unused_pc_bits = ^{bus.lookup_pc & ~PC_USED_MASK,
                            bus.upd_pc & ~PC_USED_MASK};

endmodule

`default_nettype wire

// File: tb/tb_btb_tagged.sv
// ============================================================================
// Module      : tb_btb_tagged
// Description : Directed self-checking bench for btb_tagged (16 x 8-bit tag).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_btb_tagged;

  logic clk;
  logic rst;
  int   n_asserts;
  int   n_fails;

  btb_tagged_if bus ();

`ifdef BTB_PERF_EN
  logic [31:0] perf_lookups;
  logic [31:0] perf_hits;
`endif

  btb_tagged #(
    .ENTRIES  (16),
    .TAG_BITS (8)
  ) u_dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus)
`ifdef BTB_PERF_EN
    ,
    .perf_lookups (perf_lookups),
    .perf_hits    (perf_hits)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lookup(input logic [31:0] pc);
    bus.lookup_valid = 1'b1;
    bus.lookup_pc    = pc;
    tick();
    bus.lookup_valid = 1'b0;
  endtask

  task automatic update(input logic [31:0] pc, input logic [31:0] tgt, input logic tk);
    bus.upd_valid  = 1'b1;
    bus.upd_pc     = pc;
    bus.upd_target = tgt;
    bus.upd_taken  = tk;
    tick();
    bus.upd_valid  = 1'b0;
  endtask

  task automatic expect_pred(input string tag, input logic hit, input logic tk,
                             input logic [31:0] tgt);
    check_eq({tag, ".valid"},  {31'd0, bus.pred_valid}, 32'd1);
    check_eq({tag, ".hit"},    {31'd0, bus.pred_hit},   {31'd0, hit});
    check_eq({tag, ".taken"},  {31'd0, bus.pred_taken}, {31'd0, tk});
    check_eq({tag, ".target"}, bus.pred_target,         tgt);
  endtask

  initial begin
    n_asserts        = 0;
    n_fails          = 0;
    rst              = 1'b1;
    bus.lookup_valid = 1'b0;
    bus.lookup_pc    = '0;
    bus.upd_valid    = 1'b0;
    bus.upd_pc       = '0;
    bus.upd_target   = '0;
    bus.upd_taken    = 1'b0;
    bus.flush        = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    check_eq("rst.valid",  {31'd0, bus.pred_valid}, 32'd0);
    check_eq("rst.hit",    {31'd0, bus.pred_hit},   32'd0);
    check_eq("rst.taken",  {31'd0, bus.pred_taken}, 32'd0);
    check_eq("rst.target", bus.pred_target,         32'd0);

    // Cold miss, then allocate and hit
    lookup(32'h40);                       expect_pred("cold", 1'b0, 1'b0, 32'h0);
    update(32'h40, 32'h200, 1'b1);
    lookup(32'h40);                       expect_pred("alloc", 1'b1, 1'b1, 32'h200);

    // Idle cycle: flags drop, target holds
    tick();
    check_eq("idle.valid",  {31'd0, bus.pred_valid}, 32'd0);
    check_eq("idle.hit",    {31'd0, bus.pred_hit},   32'd0);
    check_eq("idle.taken",  {31'd0, bus.pred_taken}, 32'd0);
    check_eq("idle.target", bus.pred_target,         32'h200);

    // Aliasing on index 0 (tag 0x01 vs 0x11)
    lookup(32'h440);                      expect_pred("alias.miss", 1'b0, 1'b0, 32'h0);
    update(32'h440, 32'h300, 1'b1);
    lookup(32'h440);                      expect_pred("alias.hit", 1'b1, 1'b1, 32'h300);
    lookup(32'h40);                       expect_pred("alias.evict", 1'b0, 1'b0, 32'h0);

    // Counter saturation on 0x40, re-allocated at ctr=2
    update(32'h40, 32'h200, 1'b1);
    update(32'h40, 32'h200, 1'b0);
    update(32'h40, 32'h200, 1'b0);
    lookup(32'h40);                       expect_pred("ctr0", 1'b1, 1'b0, 32'h200);
    update(32'h40, 32'h200, 1'b0);
    lookup(32'h40);                       expect_pred("ctr0.sat", 1'b1, 1'b0, 32'h200);
    update(32'h40, 32'h200, 1'b1);
    update(32'h40, 32'h200, 1'b1);
    lookup(32'h40);                       expect_pred("ctr2", 1'b1, 1'b1, 32'h200);
    for (int i = 0; i < 3; i++) update(32'h40, 32'h200, 1'b1);
    lookup(32'h40);                       expect_pred("ctr3.sat", 1'b1, 1'b1, 32'h200);
    update(32'h40, 32'h204, 1'b0);
    lookup(32'h40);                       expect_pred("ctr3to2", 1'b1, 1'b1, 32'h204);
    update(32'h40, 32'h204, 1'b0);
    lookup(32'h40);                       expect_pred("ctr2to1", 1'b1, 1'b0, 32'h204);

    // Same-cycle lookup and allocating update: read-before-write
    bus.upd_valid = 1'b1; bus.upd_pc = 32'h80; bus.upd_target = 32'h400; bus.upd_taken = 1'b1;
    lookup(32'h80);
    bus.upd_valid = 1'b0;                 expect_pred("rbw.old", 1'b0, 1'b0, 32'h0);
    lookup(32'h80);                       expect_pred("rbw.new", 1'b1, 1'b1, 32'h400);

    // Flush with same-cycle update (dropped) and lookup (sees old state)
    update(32'h40, 32'h500, 1'b1);
    bus.flush = 1'b1;
    bus.upd_valid = 1'b1; bus.upd_pc = 32'h44; bus.upd_target = 32'h600; bus.upd_taken = 1'b1;
    lookup(32'h40);
    bus.flush = 1'b0; bus.upd_valid = 1'b0;
    expect_pred("flush.old", 1'b1, 1'b1, 32'h500);
    lookup(32'h40);                       expect_pred("flush.gone", 1'b0, 1'b0, 32'h0);
    lookup(32'h44);                       expect_pred("flush.upd_drop", 1'b0, 1'b0, 32'h0);

    // Reset in the middle of a lookup burst
    update(32'h40, 32'h700, 1'b1);
    lookup(32'h40);                       expect_pred("pre_rst.hit", 1'b1, 1'b1, 32'h700);
    lookup(32'h48);                       expect_pred("pre_rst.miss", 1'b0, 1'b0, 32'h0);
`ifdef BTB_PERF_EN
    check_eq("perf.lookups", perf_lookups, 32'd18);
    check_eq("perf.hits",    perf_hits,    32'd11);
`endif
    rst = 1'b1;
    bus.upd_valid = 1'b1; bus.upd_pc = 32'h48; bus.upd_target = 32'h800; bus.upd_taken = 1'b1;
    lookup(32'h40);
    rst = 1'b0; bus.upd_valid = 1'b0;
    check_eq("mid_rst.valid",  {31'd0, bus.pred_valid}, 32'd0);
    check_eq("mid_rst.hit",    {31'd0, bus.pred_hit},   32'd0);
    check_eq("mid_rst.taken",  {31'd0, bus.pred_taken}, 32'd0);
    check_eq("mid_rst.target", bus.pred_target,         32'd0);
`ifdef BTB_PERF_EN
    check_eq("perf.rst_lookups", perf_lookups, 32'd0);
    check_eq("perf.rst_hits",    perf_hits,    32'd0);
`endif
    lookup(32'h40);                       expect_pred("post_rst.40", 1'b0, 1'b0, 32'h0);
    lookup(32'h48);                       expect_pred("post_rst.48", 1'b0, 1'b0, 32'h0);
    lookup(32'h80);                       expect_pred("post_rst.80", 1'b0, 1'b0, 32'h0);
`ifdef BTB_PERF_EN
    check_eq("perf.post_lookups", perf_lookups, 32'd3);
    check_eq("perf.post_hits",    perf_hits,    32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule

`default_nettype wire
